// File: rtl/aes_state_pkg.sv
// Shared types and width helpers for the AES multi-context state bank.
// Slot lifecycle: IDLE -> READY -> INFLIGHT -> (READY | DONE) -> IDLE.
package aes_state_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_READY    = 2'd1,
    SLOT_INFLIGHT = 2'd2,
    SLOT_DONE     = 2'd3
  } slotState_t;

  localparam int AES_ROUNDS_256 = 14;

  function automatic int slotW(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  function automatic int rndW(input int rounds);
    return $clog2(rounds + 1);
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin selector: grants the first requesting slot at or after ptr,
// wrapping around; grantValid is high whenever any slot requests.
module aes_rr_arbiter
  import aes_state_pkg::*;
#(
  parameter int SLOTS = 4,
  localparam int SW = slotW(SLOTS)
) (
  input  logic [SLOTS-1:0] req,
  input  logic [SW-1:0]    ptr,
  output logic [SW-1:0]    grant,
  output logic             grantValid
);

  logic [SW-1:0] idx;

  // Scan offsets from the far end down so the offset closest to ptr wins last.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    idx        = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      idx = ptr + SW'(i);
      if (req[idx]) begin
        grant      = idx;
        grantValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_state_bank.sv
// Multi-context AES state bank: holds SLOTS block states, issues them round by
// round to a shared round datapath and hands finished blocks to a consumer.
module aes_state_bank
  import aes_state_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int SLOTS  = 4,
  parameter int ROUNDS = AES_ROUNDS_256,
  localparam int SW = slotW(SLOTS),
  localparam int RW = rndW(ROUNDS)
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic              inLdValid,
  input  logic [DATA_W-1:0] inLdData,
  output logic              outLdReady,
  output logic [SW-1:0]     outLdSlot,
  output logic              outRndValid,
  input  logic              inRndReady,
  output logic [SW-1:0]     outRndSlot,
  output logic [DATA_W-1:0] outRndData,
  output logic [RW-1:0]     outRndIdx,
  input  logic              inIntWr,
  input  logic [SW-1:0]     inIntSlot,
  input  logic [DATA_W-1:0] inIntData,
  output logic              outDoneValid,
  output logic [SW-1:0]     outDoneSlot,
  output logic [DATA_W-1:0] outDoneData,
  input  logic              inDoneReady,
  output logic              outErr
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

  slotState_t        stateQ [SLOTS];
  slotState_t        stateD [SLOTS];
  logic [DATA_W-1:0] dataQ  [SLOTS];
  logic [DATA_W-1:0] dataD  [SLOTS];
  logic [RW-1:0]     cntQ   [SLOTS];
  logic [RW-1:0]     cntD   [SLOTS];

  logic [SW-1:0]    rrPtrQ;
  logic [SW-1:0]    holdSlotQ;
  logic             holdValidQ;
  logic             errQ;
  logic [SLOTS-1:0] readyVec;
  logic [SW-1:0]    arbGrant;
  logic [SW-1:0]    rndSel;
  logic             arbValid;
  logic             ldFire;
  logic             rndFire;
  logic             doneFire;
  logic             intHit;

  // Lowest-index IDLE and DONE slots, found by scanning downwards.
  always_comb begin
    readyVec     = '0;
    outLdReady   = 1'b0;
    outLdSlot    = '0;
    outDoneValid = 1'b0;
    outDoneSlot  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      readyVec[i] = (stateQ[i] == SLOT_READY);
      if (stateQ[i] == SLOT_IDLE) begin
        outLdReady = 1'b1;
        outLdSlot  = SW'(i);
      end
      if (stateQ[i] == SLOT_DONE) begin
        outDoneValid = 1'b1;
        outDoneSlot  = SW'(i);
      end
    end
  end

  aes_rr_arbiter #(.SLOTS(SLOTS)) rrArb (
    .req        (readyVec),
    .ptr        (rrPtrQ),
    .grant      (arbGrant),
    .grantValid (arbValid)
  );

  // A stalled offer stays pinned even if a new READY slot would win arbitration.
  assign rndSel      = holdValidQ ? holdSlotQ : arbGrant;
  assign outRndValid = arbValid;
  assign outRndSlot  = rndSel;
  assign outRndData  = dataQ[rndSel];
  assign outRndIdx   = cntQ[rndSel];
  assign outDoneData = dataQ[outDoneSlot];
  assign outErr      = errQ;

  assign ldFire   = inLdValid & outLdReady;
  assign rndFire  = outRndValid & inRndReady;
  assign doneFire = outDoneValid & inDoneReady;
  assign intHit   = inIntWr & (stateQ[inIntSlot] == SLOT_INFLIGHT);

  // Per-slot next state; each action needs a distinct current state, and the
  // writeback is applied last so it owns the data register on any overlap.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      stateD[i] = stateQ[i];
      dataD[i]  = dataQ[i];
      cntD[i]   = cntQ[i];
      if (ldFire && outLdSlot == SW'(i)) begin
        stateD[i] = SLOT_READY;
        dataD[i]  = inLdData;
        cntD[i]   = '0;
      end
      if (rndFire && rndSel == SW'(i)) begin
        stateD[i] = SLOT_INFLIGHT;
      end
      if (doneFire && outDoneSlot == SW'(i)) begin
        stateD[i] = SLOT_IDLE;
      end
      if (intHit && inIntSlot == SW'(i)) begin
        dataD[i]  = inIntData;
        cntD[i]   = cntQ[i] + RW'(1);
        stateD[i] = (cntD[i] == LAST_ROUND) ? SLOT_DONE : SLOT_READY;
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      for (int i = 0; i < SLOTS; i++) begin
        stateQ[i] <= SLOT_IDLE;
        dataQ[i]  <= '0;
        cntQ[i]   <= '0;
      end
      rrPtrQ     <= '0;
      holdValidQ <= 1'b0;
      holdSlotQ  <= '0;
      errQ       <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        stateQ[i] <= stateD[i];
        dataQ[i]  <= dataD[i];
        cntQ[i]   <= cntD[i];
      end
      if (rndFire) begin
        rrPtrQ <= rndSel + SW'(1);
      end
      holdValidQ <= outRndValid & ~inRndReady;
      holdSlotQ  <= rndSel;
      if (inIntWr && !intHit) begin
        errQ <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_state_bank.sv
// Scoreboard bench for aes_state_bank: finished blocks are predicted at load
// time and compared when the bank presents them on the done port.
module tb_aes_state_bank;

  localparam int DATA_W = 128;
  localparam int SLOTS  = 4;
  localparam int ROUNDS = 14;
  localparam int SW     = 2;
  localparam int RW     = 4;

  logic              inClk;
  logic              inRst;
  logic              inLdValid;
  logic [DATA_W-1:0] inLdData;
  logic              outLdReady;
  logic [SW-1:0]     outLdSlot;
  logic              outRndValid;
  logic              inRndReady;
  logic [SW-1:0]     outRndSlot;
  logic [DATA_W-1:0] outRndData;
  logic [RW-1:0]     outRndIdx;
  logic              inIntWr;
  logic [SW-1:0]     inIntSlot;
  logic [DATA_W-1:0] inIntData;
  logic              outDoneValid;
  logic [SW-1:0]     outDoneSlot;
  logic [DATA_W-1:0] outDoneData;
  logic              inDoneReady;
  logic              outErr;

  typedef struct {
    logic [SW-1:0]     slot;
    logic [DATA_W-1:0] data;
  } doneExp_t;

  doneExp_t          sbQ[$];
  int                testsRun    = 0;
  int                testsFailed = 0;
  logic [DATA_W-1:0] modelData [SLOTS];
  int                modelCnt  [SLOTS];
  logic [DATA_W-1:0] blkA;
  logic [DATA_W-1:0] blkB;

  aes_state_bank dut (
    .inClk        (inClk),
    .inRst        (inRst),
    .inLdValid    (inLdValid),
    .inLdData     (inLdData),
    .outLdReady   (outLdReady),
    .outLdSlot    (outLdSlot),
    .outRndValid  (outRndValid),
    .inRndReady   (inRndReady),
    .outRndSlot   (outRndSlot),
    .outRndData   (outRndData),
    .outRndIdx    (outRndIdx),
    .inIntWr      (inIntWr),
    .inIntSlot    (inIntSlot),
    .inIntData    (inIntData),
    .outDoneValid (outDoneValid),
    .outDoneSlot  (outDoneSlot),
    .outDoneData  (outDoneData),
    .inDoneReady  (inDoneReady),
    .outErr       (outErr)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ldValid, input logic [DATA_W-1:0] ldData,
                               input logic rndReady, input logic intWr,
                               input logic [SW-1:0] intSlot,
                               input logic [DATA_W-1:0] intData, input logic doneReady);
    inLdValid   = ldValid;
    inLdData    = ldData;
    inRndReady  = rndReady;
    inIntWr     = intWr;
    inIntSlot   = intSlot;
    inIntData   = intData;
    inDoneReady = doneReady;
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ldReady"}, outLdReady, 1);
    checkOutput({tag, "_ldSlot"}, outLdSlot, 0);
    checkOutput({tag, "_rndValid"}, outRndValid, 0);
    checkOutput({tag, "_rndSlot"}, outRndSlot, 0);
    checkOutput({tag, "_rndData"}, outRndData, 0);
    checkOutput({tag, "_rndIdx"}, outRndIdx, 0);
    checkOutput({tag, "_doneValid"}, outDoneValid, 0);
    checkOutput({tag, "_doneSlot"}, outDoneSlot, 0);
    checkOutput({tag, "_doneData"}, outDoneData, 0);
    checkOutput({tag, "_err"}, outErr, 0);
  endtask

  task automatic popDone(input string tag);
    doneExp_t e;
    checkOutput({tag, "_sbNotEmpty"}, DATA_W'(sbQ.size() != 0), 1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_doneValid"}, outDoneValid, 1);
      checkOutput({tag, "_doneSlot"}, outDoneSlot, DATA_W'(e.slot));
      checkOutput({tag, "_doneData"}, outDoneData, e.data);
    end
  endtask

  function automatic logic [DATA_W-1:0] wbValue(input int slot, input int round);
    return DATA_W'(slot * 256 + round);
  endfunction

  function automatic logic [DATA_W-1:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int issued;
    int expSlot;
    logic wbPend;
    logic [SW-1:0] wbSlot;
    logic doIssue;
    logic doWb;
    logic [DATA_W-1:0] wbData;

    idle();
    inRst = 1'b1;
    tick();
    tick();
    inRst = 1'b0;
    checkResetOutputs("reset");

    // First load lands in slot 0 and is offered for round 0 next cycle
    blkA = 128'h000102030405060708090a0b0c0d0e0f;
    applyStimulus(1'b1, blkA, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("firstLdReady", outLdReady, 1);
    checkOutput("firstLdSlot", outLdSlot, 0);
    sbQ.push_back('{slot: 2'd0, data: DATA_W'(ROUNDS)});
    tick();
    idle();
    checkOutput("firstRndValid", outRndValid, 1);
    checkOutput("firstRndSlot", outRndSlot, 0);
    checkOutput("firstRndIdx", outRndIdx, 0);
    checkOutput("firstRndData", outRndData, blkA);

    // Single block through all rounds, writeback data = round number
    for (int r = 1; r <= ROUNDS; r++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
      checkOutput("singleRndValid", outRndValid, 1);
      checkOutput("singleRndIdx", outRndIdx, DATA_W'(r - 1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, DATA_W'(r), 1'b0);
      checkOutput("singleInflightValid", outRndValid, 0);
      checkOutput("singleNoEarlyDone", outDoneValid, 0);
      tick();
      idle();
      if (r < ROUNDS) begin
        checkOutput("singleStillNotDone", outDoneValid, 0);
        checkOutput("singleWbData", outRndData, DATA_W'(r));
      end
    end
    checkOutput("singleRndValidAtDone", outRndValid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    popDone("singleDrain");
    tick();
    idle();
    checkOutput("singleFreedDone", outDoneValid, 0);
    checkOutput("singleFreedLd", outLdReady, 1);

    // Four blocks interleaved round-robin with writeback one cycle after issue
    for (int s = 0; s < SLOTS; s++) begin
      modelData[s] = randBlock();
      modelCnt[s]  = 0;
      applyStimulus(1'b1, modelData[s], 1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput("rrLdSlot", outLdSlot, DATA_W'(s));
      sbQ.push_back('{slot: SW'(s), data: wbValue(s, ROUNDS)});
      tick();
    end
    idle();
    checkOutput("rrFullLdReady", outLdReady, 0);
    issued  = 0;
    expSlot = 0;
    wbPend  = 1'b0;
    wbSlot  = '0;
    for (int c = 0; c < 300 && (issued < ROUNDS * SLOTS || wbPend); c++) begin
      doWb    = wbPend;
      doIssue = (issued < ROUNDS * SLOTS);
      wbData  = doWb ? wbValue(int'(wbSlot), modelCnt[wbSlot] + 1) : '0;
      applyStimulus(1'b0, '0, doIssue, doWb, wbSlot, wbData, 1'b0);
      checkOutput("rrBusyLdReady", outLdReady, 0);
      if (doIssue) begin
        checkOutput("rrValid", outRndValid, 1);
        checkOutput("rrSlot", outRndSlot, DATA_W'(expSlot));
        checkOutput("rrIdx", outRndIdx, DATA_W'(modelCnt[expSlot]));
        checkOutput("rrData", outRndData, modelData[expSlot]);
      end
      tick();
      if (doWb) begin
        modelData[wbSlot] = wbData;
        modelCnt[wbSlot]  = modelCnt[wbSlot] + 1;
      end
      if (doIssue) begin
        wbPend  = 1'b1;
        wbSlot  = SW'(expSlot);
        expSlot = (expSlot + 1) % SLOTS;
        issued++;
      end else begin
        wbPend = 1'b0;
      end
    end
    idle();
    checkOutput("rrBudget", DATA_W'(issued == ROUNDS * SLOTS && !wbPend), 1);
    checkOutput("rrAllDoneValid", outDoneValid, 1);
    checkOutput("rrAllDoneLdReady", outLdReady, 0);
    checkOutput("rrAllDoneRndValid", outRndValid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < SLOTS; k++) begin
      popDone("rrDrain");
      tick();
    end
    idle();
    checkOutput("rrDrainedLdReady", outLdReady, 1);
    checkOutput("rrDrainedDone", outDoneValid, 0);

    // Slot 2 finishes while 0,1,3 are in flight; drain and load collide
    for (int s = 0; s < SLOTS; s++) begin
      applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
    end
    for (int s = 0; s < SLOTS; s++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
      checkOutput("colIssueSlot", outRndSlot, DATA_W'(s));
      tick();
    end
    idle();
    checkOutput("colAllInflight", outRndValid, 0);
    sbQ.push_back('{slot: 2'd2, data: wbValue(2, ROUNDS)});
    for (int r = 1; r <= ROUNDS; r++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd2, wbValue(2, r), 1'b0);
      tick();
      idle();
      if (r < ROUNDS) begin
        checkOutput("colSlot2Valid", outRndValid, 1);
        checkOutput("colSlot2Slot", outRndSlot, 2);
        checkOutput("colSlot2Idx", outRndIdx, DATA_W'(r));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
      end
    end
    blkB = randBlock();
    applyStimulus(1'b1, blkB, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("colLdBlocked", outLdReady, 0);
    popDone("colDrain");
    tick();
    applyStimulus(1'b1, blkB, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("colLdReadyAfter", outLdReady, 1);
    checkOutput("colLdSlotAfter", outLdSlot, 2);
    checkOutput("colDoneCleared", outDoneValid, 0);
    tick();
    idle();
    checkOutput("colNewValid", outRndValid, 1);
    checkOutput("colNewSlot", outRndSlot, 2);
    checkOutput("colNewIdx", outRndIdx, 0);
    checkOutput("colNewData", outRndData, blkB);

    // Protocol error: writeback to IDLE and to READY slots is ignored
    inRst = 1'b1;
    tick();
    inRst = 1'b0;
    checkOutput("errClearAfterReset", outErr, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, 128'hDEAD, 1'b0);
    tick();
    idle();
    checkOutput("errIdleWb", outErr, 1);
    blkA = randBlock();
    blkB = randBlock();
    applyStimulus(1'b1, blkA, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, blkB, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("errIssueSlot0", outRndSlot, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, 128'hBAD, 1'b0);
    tick();
    idle();
    checkOutput("errReadySlot", outRndSlot, 1);
    checkOutput("errReadyData", outRndData, blkB);
    checkOutput("errReadyIdx", outRndIdx, 0);
    checkOutput("errSticky", outErr, 1);
    inRst = 1'b1;
    applyStimulus(1'b1, randBlock(), 1'b1, 1'b1, 2'd0, 128'h1, 1'b1);
    tick();
    inRst = 1'b0;
    idle();
    checkResetOutputs("errReset");

    // Reset discards two blocks in flight at round 7
    applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    for (int r = 0; r < 7; r++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
      checkOutput("midSlot0", outRndSlot, 0);
      tick();
      checkOutput("midSlot1", outRndSlot, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, wbValue(0, r + 1), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, wbValue(1, r + 1), 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("midIdx0", outRndIdx, 7);
    checkOutput("midData0", outRndData, wbValue(0, 7));
    tick();
    checkOutput("midIdx1", outRndIdx, 7);
    tick();
    idle();
    checkOutput("midInflight", outRndValid, 0);
    inRst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, 128'h55, 1'b0);
    tick();
    inRst = 1'b0;
    idle();
    checkResetOutputs("midReset");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, 128'h77, 1'b0);
    tick();
    idle();
    checkOutput("midStaleWbErr", outErr, 1);
    checkOutput("midStaleWbNoValid", outRndValid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
